seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4: number of clock cycles each digit is driven (legal range 1..255).
REQ-002 SHALL have parameter BLANK_CYC, default 1: number of blanking cycles before each digit (legal range 0..255; 0 means no blanking).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: scan enable.
REQ-006 SHALL have port load, input, 1 bit: one-cycle write strobe for data_in.
REQ-007 SHALL have port data_in, input, 16 bits: four 4-bit digit codes; digit i is data_in[4i+3:4i].
REQ-008 SHALL have port nibble, output, 4 bits: code fed to the shared seven-segment decoder inputs A,B,C,D (nibble[3]=A).
REQ-009 SHALL have port digit_en, output, 4 bits: one-hot active-high digit select; all zero while blanking or disabled.
REQ-010 SHALL have port blank, output, 1 bit: high whenever digit_en is all zero.
REQ-011 SHALL have port pending, output, 1 bit: shadow register holds data not yet displayed.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse on the first cycle of each new frame.

Function
REQ-013 SHALL hold a 16-bit display register disp, a 16-bit shadow register shadow, a 2-bit digit index idx, a cycle counter, and a 2-state FSM {BLANK, SHOW}; all outputs SHALL be registered.
REQ-014 load=1 SHALL write data_in into shadow and set pending at the next edge; load while pending=1 SHALL overwrite shadow (last write wins).
REQ-015 In BLANK, the block SHALL stay BLANK_CYC cycles with digit_en=0, then enter SHOW; with BLANK_CYC=0, BLANK SHALL be skipped entirely.
REQ-016 In SHOW, digit_en SHALL equal 1<<idx for exactly DIV cycles, then the FSM SHALL return to BLANK with idx incremented modulo 4.
REQ-017 nibble SHALL equal disp[4*idx+3:4*idx] in both BLANK and SHOW, so the decoder settles during blanking.
REQ-018 Frame length SHALL be 4*(BLANK_CYC+DIV) cycles; with the defaults it is 20.
REQ-019 At wrap from idx=3 to idx=0, if pending=1, disp SHALL take shadow and pending SHALL clear in the same edge.
REQ-020 frame_done SHALL be high for exactly one cycle: the first cycle of the new frame.
REQ-021 If load=1 on the wrap edge, disp SHALL take data_in directly, and pending SHALL end at 0.
REQ-022 disp SHALL never change except at a frame wrap.
REQ-023 When en=0, the block SHALL, at the next edge, force digit_en=0, blank=1, FSM=BLANK, idx=0, counter=0.
REQ-024 While en=0, load/pending/shadow SHALL keep operating; no transfer into disp and no frame_done SHALL occur.
REQ-025 When en rises, scanning SHALL restart from digit 0 with a full blanking interval, and the first wrap SHALL apply the transfer rule.

Reset
REQ-026 While rst=1, state SHALL be forced immediately, independent of clk: disp=0, shadow=0, pending=0, idx=0, counter=0, FSM=BLANK.
REQ-027 The resulting outputs during reset SHALL be nibble=0000, digit_en=0000, blank=1, frame_done=0.
REQ-028 Reset asserted mid-frame SHALL discard pending data; after release with en=1, the first SHOW SHALL begin BLANK_CYC cycles later on digit 0.

Verification
REQ-029 Defaults, en=1, no load, after reset -> digit_en sequence 0000,0001x4,0000,0010x4,0000,0100x4,0000,1000x4; frame_done pulses at cycle 20; nibble=0000 throughout.
REQ-030 load data_in=16'h4321 at cycle 3 -> pending=1 from cycle 4; digit 0 still shows 0; disp=4321 and frame_done at cycle 20; nibble then 1,2,3,4 per digit; pending=0.
REQ-031 load 16'hAAAA then 16'h5555 in the same frame -> next frame shows 5,5,5,5 only.
REQ-032 load 16'hBEEF exactly on the wrap edge -> next frame shows F,E,E,B; pending=0 afterwards.
REQ-033 en dropped mid-SHOW of digit 2 for 7 cycles, then raised -> digit_en=0 from the next edge; restart shows 1 blank cycle, then digit 0.
REQ-034 DIV=1, BLANK_CYC=0 -> digit_en rotates 0001,0010,0100,1000 every cycle; blank never high; frame_done every 4 cycles.
REQ-035 rst asserted asynchronously mid-frame with pending=1 -> outputs reach reset values before the next clk edge; pending=0 after release.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a four-digit seven-segment display that
// shares one decoder. Each digit gets BLANK_CYC dark cycles so the shared
// decoder can settle, then DIV lit cycles. New display data is written into a
// shadow register and copied into the live display register only when the scan
// wraps from digit 3 to digit 0, so a frame never shows a mix of old and new
// digits.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         scan enable; low forces the display dark and rewinds to digit 0
//   load       one-cycle write strobe for data_in
//   data_in    four digit codes, digit i = data_in[4i+3:4i]
//   nibble     code for the shared decoder (nibble[3] = A input)
//   digit_en   one-hot active-high digit select, zero while dark
//   blank      high whenever digit_en is zero
//   pending    shadow register holds data not yet shown
//   frame_done one-cycle pulse on the first cycle of each new frame
//
// Write handshake: there is no back-pressure. Every cycle with load=1 is
// accepted at the next rising edge; a write while pending=1 overwrites the
// shadow (last write wins). A write on the wrap edge goes straight to the
// display and leaves pending clear.
module seg_scan_ctrl #(
   parameter int DIV       = 4,
   parameter int BLANK_CYC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] data_in,
   output logic [3:0]  nibble,
   output logic [3:0]  digit_en,
   output logic        blank,
   output logic        pending,
   output logic        frame_done
);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   localparam logic [7:0] DIV_LAST   = 8'(DIV - 1);
   localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);
   localparam bit         NO_BLANK   = (BLANK_CYC == 0);

   state_t      state, state_n;
   logic [1:0]  idx, idx_n;
   logic [7:0]  cnt, cnt_n;
   logic [15:0] disp, disp_n;
   logic [15:0] shadow, shadow_n;
   logic        pending_n;
   logic        wrap;
   logic [3:0]  digit_en_n;
   logic [3:0]  nibble_n;

   // Next-state and next-output logic. Outputs are registered from the
   // next-state values so every output changes cleanly on the clock edge.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      cnt_n     = cnt;
      disp_n    = disp;
      shadow_n  = shadow;
      pending_n = pending;
      wrap      = 1'b0;

      // The write path keeps working even while scanning is disabled.
      if (load) begin
         shadow_n  = data_in;
         pending_n = 1'b1;
      end

      if (!en) begin
         state_n = ST_BLANK;
         idx_n   = 2'd0;
         cnt_n   = 8'd0;
      end else begin
         case (state)
            ST_BLANK: begin
               // With no blanking configured, BLANK is only ever entered from
               // reset or disable and is left on the very next edge.
               if (NO_BLANK || cnt == BLANK_LAST) begin
                  state_n = ST_SHOW;
                  cnt_n   = 8'd0;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            ST_SHOW: begin
               if (cnt == DIV_LAST) begin
                  cnt_n   = 8'd0;
                  idx_n   = idx + 2'd1;
                  state_n = NO_BLANK ? ST_SHOW : ST_BLANK;
                  wrap    = (idx == 2'd3);
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            default: begin
               state_n = ST_BLANK;
               cnt_n   = 8'd0;
            end
         endcase
      end

      // Frame wrap is the only point where the live display register changes.
      // A write landing on the wrap edge bypasses the shadow entirely.
      if (wrap) begin
         if (load) begin
            disp_n = data_in;
         end else if (pending) begin
            disp_n = shadow;
         end
         pending_n = 1'b0;
      end

      digit_en_n = (state_n == ST_SHOW) ? (4'b0001 << idx_n) : 4'b0000;
      // The code for the upcoming digit is presented during its blanking
      // interval as well, giving the decoder time to settle before lighting.
      nibble_n   = disp_n[{idx_n, 2'b00} +: 4];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_BLANK;
         idx        <= 2'd0;
         cnt        <= 8'd0;
         disp       <= 16'h0000;
         shadow     <= 16'h0000;
         pending    <= 1'b0;
         nibble     <= 4'h0;
         digit_en   <= 4'h0;
         blank      <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         disp       <= disp_n;
         shadow     <= shadow_n;
         pending    <= pending_n;
         nibble     <= nibble_n;
         digit_en   <= digit_en_n;
         blank      <= (state_n != ST_SHOW);
         frame_done <= wrap;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl. Two instances share all inputs: one with the
// default timing (DIV=4, BLANK_CYC=1) and one with DIV=1, BLANK_CYC=0.
// A reference model describes each instance by its position inside the frame
// and derives the expected outputs arithmetically from that position.
module tb_seg_scan_ctrl;

   localparam int B_A = 1;
   localparam int D_A = 4;
   localparam int B_B = 0;
   localparam int D_B = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] data_in = 16'h0000;

   logic [3:0] nib_a, den_a, nib_b, den_b;
   logic       blk_a, pend_a, fd_a, blk_b, pend_b, fd_b;

   int tests = 0;
   int fails = 0;

   // Expected output vector: {nibble, digit_en, blank, pending, frame_done}
   logic [10:0] exp_a[$];
   logic [10:0] exp_b[$];

   // Reference model state per instance
   int          m_pos[2];
   logic [15:0] m_disp[2];
   logic [15:0] m_shadow[2];
   logic        m_pend[2];

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIV(D_A), .BLANK_CYC(B_A)) dut_a (
      .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
      .nibble(nib_a), .digit_en(den_a), .blank(blk_a), .pending(pend_a),
      .frame_done(fd_a)
   );

   seg_scan_ctrl #(.DIV(D_B), .BLANK_CYC(B_B)) dut_b (
      .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
      .nibble(nib_b), .digit_en(den_b), .blank(blk_b), .pending(pend_b),
      .frame_done(fd_b)
   );

   task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s at %0t: got nib=%h den=%b blank=%b pend=%b fd=%b, expected nib=%h den=%b blank=%b pend=%b fd=%b",
                  name, $time, got[10:7], got[6:3], got[2], got[1], got[0],
                  want[10:7], want[6:3], want[2], want[1], want[0]);
      end
   endtask

   // Advance the model of instance k across one clock edge using the inputs
   // currently driven, and return the outputs expected after that edge.
   // Position -1 is the dark idle cycle that exists only when there is no
   // blanking interval; otherwise idle coincides with the first blank slot.
   task automatic model_step(input int k, input int b, input int d, output logic [10:0] e);
      int          flen, dig, slot;
      logic        fd;
      logic [3:0]  den;
      logic [15:0] shifted;
      flen = 4 * (b + d);
      fd   = 1'b0;
      if (rst) begin
         m_pos[k]    = (b == 0) ? -1 : 0;
         m_disp[k]   = 16'h0000;
         m_shadow[k] = 16'h0000;
         m_pend[k]   = 1'b0;
      end else begin
         if (!en) begin
            m_pos[k] = (b == 0) ? -1 : 0;
         end else begin
            m_pos[k] = m_pos[k] + 1;
            if (m_pos[k] == flen) begin
               m_pos[k] = 0;
               fd = 1'b1;
            end
         end
         if (fd) begin
            if (load) m_disp[k] = data_in;
            else if (m_pend[k]) m_disp[k] = m_shadow[k];
            if (load) m_shadow[k] = data_in;
            m_pend[k] = 1'b0;
         end else if (load) begin
            m_shadow[k] = data_in;
            m_pend[k]   = 1'b1;
         end
      end
      if (m_pos[k] < 0) begin
         dig = 0;
         den = 4'b0000;
      end else begin
         dig  = m_pos[k] / (b + d);
         slot = m_pos[k] % (b + d);
         den  = (slot < b) ? 4'b0000 : (4'b0001 << dig);
      end
      shifted = m_disp[k] >> (4 * dig);
      e = {shifted[3:0], den, (den == 4'b0000), m_pend[k], fd};
   endtask

   // Drive one cycle of stimulus at the falling edge and queue the response
   // expected after the following rising edge.
   task automatic drive(input logic r, input logic e_i, input logic l, input logic [15:0] d);
      logic [10:0] e;
      @(negedge clk);
      rst     = r;
      en      = e_i;
      load    = l;
      data_in = d;
      model_step(0, B_A, D_A, e);
      exp_a.push_back(e);
      model_step(1, B_B, D_B, e);
      exp_b.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 16'h0000);
   endtask

   // Run until the default instance is about to show frame position target.
   task automatic run_until(input int target);
      for (int i = 0; i < 60 && m_pos[0] != target; i++) drive(1'b0, 1'b1, 1'b0, 16'h0000);
      tests++;
      if (m_pos[0] != target) begin
         fails++;
         $display("FAIL align: frame position %0d, expected %0d", m_pos[0], target);
      end
   endtask

   // Monitor: compare every presented output cycle against the queue head.
   initial begin
      logic [10:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            check("scan_a", {nib_a, den_a, blk_a, pend_a, fd_a}, e);
         end
         if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            check("scan_b", {nib_b, den_b, blk_b, pend_b, fd_b}, e);
         end
      end
   end

   initial begin
      // Reset state, then a plain scan of an all-zero display
      drive(1'b1, 1'b1, 1'b0, 16'h0000);
      drive(1'b1, 1'b1, 1'b0, 16'h0000);
      idle(22);

      // Write mid-frame: shadow first, display at the wrap
      run_until(2);
      drive(1'b0, 1'b1, 1'b1, 16'h4321);
      idle(40);

      // Two writes in one frame: last one wins
      run_until(5);
      drive(1'b0, 1'b1, 1'b1, 16'hAAAA);
      idle(3);
      drive(1'b0, 1'b1, 1'b1, 16'h5555);
      idle(40);

      // Write exactly on the wrap edge
      run_until(19);
      drive(1'b0, 1'b1, 1'b1, 16'hBEEF);
      idle(25);

      // Disable in the middle of digit 2, write while disabled, re-enable
      run_until(12);
      for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, (i == 3), 16'h9876);
      idle(45);

      // Asynchronous reset mid-frame with data pending
      run_until(6);
      drive(1'b0, 1'b1, 1'b1, 16'h1234);
      idle(3);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_a", {nib_a, den_a, blk_a, pend_a, fd_a}, 11'b0000_0000_1_0_0);
      check("async_rst_b", {nib_b, den_b, blk_b, pend_b, fd_b}, 11'b0000_0000_1_0_0);
      drive(1'b1, 1'b1, 1'b0, 16'h0000);
      drive(1'b1, 1'b1, 1'b0, 16'h0000);
      idle(25);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive(1'b0, ($urandom_range(0, 24) != 0), ($urandom_range(0, 6) == 0), 16'($urandom));
      end
      idle(4);

      @(posedge clk);
      #4;
      tests++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d/%0d expected entries left, required 0/0", exp_a.size(), exp_b.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
